// File: rtl/clk_sched_pkg.sv
// Shared definitions for the clock-enable scheduler.
//   top_state_e   : encodings of the top-level FSM state
//   div_of_state  : maps a state code to its divide ratio
package clk_sched_pkg;

    localparam int unsigned TOP_STATE_W = 4;

    typedef enum logic [TOP_STATE_W-1:0] {
        StReset    = 4'd0,
        StIdle     = 4'd1,
        StConv1_1  = 4'd2,
        StConv1_2  = 4'd3,
        StAvgPool1 = 4'd4,
        StConv2_1  = 4'd5,
        StConv2_2  = 4'd6,
        StAvgPool2 = 4'd7,
        StConv3_1  = 4'd8,
        StConv3_2  = 4'd9,
        StAvgPool3 = 4'd10,
        StFc       = 4'd11,
        StJudge    = 4'd12
    } top_state_e;

    // Raw table lookup; the caller truncates to its counter width and maps 0 to 1.
    function automatic int unsigned div_of_state(input int unsigned code,
                                                 input int unsigned div_conv,
                                                 input int unsigned div_pool,
                                                 input int unsigned div_default);
        int unsigned div;
        case (code)
            32'(StConv1_1), 32'(StConv1_2), 32'(StConv2_1),
            32'(StConv2_2), 32'(StConv3_1), 32'(StConv3_2):  div = div_conv;
            32'(StAvgPool1), 32'(StAvgPool2), 32'(StAvgPool3): div = div_pool;
            default:                                           div = div_default;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/clken_divider.sv
// Period counter and registered enable generator.
//   clk, rst   : system clock, async active-high reset
//   hold       : freeze counter and divisor, force clk_en low
//   load       : take nxt_div at the next period boundary
//   nxt_div    : divisor to adopt on load
//   boundary   : combinational, last count of the period and not held
//   cur_div    : divisor in force
//   clk_en     : one-cycle pulse per period (continuous when cur_div=1)
module clken_divider #(
    parameter int unsigned          CNT_W     = 4,
    parameter logic [CNT_W-1:0]     RESET_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             load,
    input  logic [CNT_W-1:0] nxt_div,
    output logic             boundary,
    output logic [CNT_W-1:0] cur_div,
    output logic             clk_en
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cur_div_q;
    logic             clk_en_q;

    always_comb begin
        boundary = (cnt_q == cur_div_q - CNT_W'(1)) && !hold;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            cur_div_q <= RESET_DIV;
            clk_en_q  <= 1'b0;
        end else begin
            clk_en_q <= boundary;
            if (boundary) begin
                cnt_q <= '0;
                if (load) begin
                    cur_div_q <= nxt_div;
                end
            end else if (!hold) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign cur_div = cur_div_q;
    assign clk_en  = clk_en_q;

endmodule

// File: rtl/clk_enable_sched.sv
// Per-state clock-enable scheduler: looks up a divide ratio from the top FSM
// state and switches the divider to it only on period boundaries.
// Optional feature macro: CLKEN_PERF_CNT_EN (enables the en_count pulse counter).
//   clk, rst  : system clock, async active-high reset
//   State     : current top-FSM state
//   hold      : stall divider, clk_en forced low
//   cnt_clr   : sync clear of en_count (perf counter builds only)
//   clk_en    : registered enable pulse
//   cur_div   : divisor in force
//   pending   : a different divisor is waiting for a boundary
//   en_count  : number of clk_en pulses issued (0 when counter not built)
module clk_enable_sched
    import clk_sched_pkg::*;
#(
    parameter int unsigned STATE_DATAWIDTH = 4,
    parameter int unsigned CNT_W           = 4,
    parameter int unsigned DIV_CONV        = 1,
    parameter int unsigned DIV_POOL        = 3,
    parameter int unsigned DIV_DEFAULT     = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [STATE_DATAWIDTH-1:0] State,
    input  logic                       hold,
    input  logic                       cnt_clr,
    output logic                       clk_en,
    output logic [CNT_W-1:0]           cur_div,
    output logic                       pending,
    output logic [31:0]                en_count
);

    localparam logic [CNT_W-1:0] DEF_RAW   = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] RESET_DIV = (DEF_RAW == '0) ? CNT_W'(1) : DEF_RAW;

    logic [CNT_W-1:0] tgt_raw;
    logic [CNT_W-1:0] tgt_div;
    logic [CNT_W-1:0] nxt_div_q;
    logic             pending_q;
    logic             pending_d;
    logic             load;
    logic             boundary;

    always_comb begin
        tgt_raw = CNT_W'(div_of_state(32'(State), DIV_CONV, DIV_POOL, DIV_DEFAULT));
        tgt_div = (tgt_raw == '0) ? CNT_W'(1) : tgt_raw;
        // A request that has returned to the current divisor is cancelled, not applied.
        load = pending_q && (tgt_div != cur_div);
        // If the boundary swaps divisors this cycle, compare against the new one so a
        // simultaneous fresh request becomes pending right after the switch.
        pending_d = (tgt_div != ((boundary && load) ? nxt_div_q : cur_div));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nxt_div_q <= RESET_DIV;
            pending_q <= 1'b0;
        end else begin
            nxt_div_q <= tgt_div;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

    clken_divider #(
        .CNT_W     (CNT_W),
        .RESET_DIV (RESET_DIV)
    ) u_divider (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .load     (load),
        .nxt_div  (nxt_div_q),
        .boundary (boundary),
        .cur_div  (cur_div),
        .clk_en   (clk_en)
    );

`ifdef CLKEN_PERF_CNT_EN
    logic [31:0] en_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_count_q <= '0;
        end else if (cnt_clr) begin
            en_count_q <= '0;
        end else if (clk_en) begin
            en_count_q <= en_count_q + 32'd1;
        end
    end

    assign en_count = en_count_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign en_count       = '0;
`endif

endmodule

// File: tb/tb_clk_enable_sched.sv
module tb_clk_enable_sched;
    import clk_sched_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  State;
    logic        hold;
    logic        cnt_clr;
    logic        clk_en;
    logic [3:0]  cur_div;
    logic        pending;
    logic [31:0] en_count;

    int n_vec;
    int n_err;
    int pulses;

    clk_enable_sched dut (
        .clk      (clk),
        .rst      (rst),
        .State    (State),
        .hold     (hold),
        .cnt_clr  (cnt_clr),
        .clk_en   (clk_en),
        .cur_div  (cur_div),
        .pending  (pending),
        .en_count (en_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic en, input logic [3:0] div,
                             input logic pend);
        check({tag, "_clk_en"}, 32'(clk_en), 32'(en));
        check({tag, "_cur_div"}, 32'(cur_div), 32'(div));
        check({tag, "_pending"}, 32'(pending), 32'(pend));
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        pulses  = 0;
        rst     = 1'b1;
        State   = StIdle;
        hold    = 1'b0;
        cnt_clr = 1'b0;
        repeat (2) tick();
        check_out("reset", 1'b0, 4'd3, 1'b0);
        check("reset_en_count", en_count, 32'd0);
        rst = 1'b0;

        // Divide-by-3 from reset: pulses after the 3rd and 6th edge.
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_out($sformatf("idle_e%0d", i), (i % 3) == 0, 4'd3, 1'b0);
        end
        tick();
        check_out("idle_cnt1", 1'b0, 4'd3, 1'b0);

        // Switch to CONV mid-period: divisor changes only at the boundary.
        State = StConv1_1;
        tick();
        check_out("conv_req", 1'b0, 4'd3, 1'b1);
        tick();
        check_out("conv_switch", 1'b1, 4'd1, 1'b0);
        tick();
        check_out("conv_run1", 1'b1, 4'd1, 1'b0);
        tick();
        check_out("conv_run2", 1'b1, 4'd1, 1'b0);

        // Brief excursion to a pool state that returns before it can take effect.
        State = StConv2_2;
        tick();
        check_out("glitch_c22", 1'b1, 4'd1, 1'b0);
        State = StAvgPool2;
        tick();
        check_out("glitch_pool", 1'b1, 4'd1, 1'b1);
        State = StConv3_1;
        tick();
        check_out("glitch_c31", 1'b1, 4'd1, 1'b0);
        tick();
        check_out("glitch_after", 1'b1, 4'd1, 1'b0);

        // Back to IDLE (div 3), then hold at cnt=2 for 5 cycles.
        State = StIdle;
        tick();
        check_out("idle_req", 1'b1, 4'd1, 1'b1);
        tick();
        check_out("idle_switch", 1'b1, 4'd3, 1'b0);
        tick();
        check_out("idle_cnt1b", 1'b0, 4'd3, 1'b0);
        tick();
        check_out("idle_cnt2b", 1'b0, 4'd3, 1'b0);
        hold = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_out($sformatf("hold_%0d", i), 1'b0, 4'd3, 1'b0);
        end
        hold = 1'b0;
        tick();
        check_out("hold_release", 1'b1, 4'd3, 1'b0);
        tick();
        check_out("hold_after", 1'b0, 4'd3, 1'b0);

        // Into a CONV state, then async reset at cnt=0.
        State = StConv1_2;
        tick();
        check_out("c12_req", 1'b0, 4'd3, 1'b1);
        tick();
        check_out("c12_switch", 1'b1, 4'd1, 1'b0);
        #3 rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 4'd3, 1'b0);
        check("async_rst_en_count", en_count, 32'd0);
        State = StIdle;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_out($sformatf("post_rst_e%0d", i), i == 3, 4'd3, 1'b0);
        end

        // Clear during a pulse, then count 10 pulses.
        cnt_clr = 1'b1;
        tick();
        check_out("clr_edge", 1'b0, 4'd3, 1'b0);
        check("clr_during_pulse", en_count, 32'd0);
        cnt_clr = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (clk_en) pulses++;
        end
        check("pulse_total", 32'(pulses), 32'd10);
`ifdef CLKEN_PERF_CNT_EN
        check("en_count_10", en_count, 32'd10);
`else
        check("en_count_tied", en_count, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
